x_mem_resp: RTL and testbench
=============================

X_MEM_RESP -- requirements
Module: x_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 256, memory size in 32-bit words (power of two, 4..4096).
REQ-002 SHALL have parameter BASE, default 32'h0000_0000, byte base address of the array (aligned to 4*DEPTH).
REQ-003 SHALL have parameter WAIT, default 2, wait cycles before accept (0..15).
REQ-004 SHALL have port i_clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port i_nrst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_valid  input  1  request present, held by the initiator until accepted.
REQ-007 SHALL have port i_rnw  input  1  1 = read, 0 = write.
REQ-008 SHALL have port i_addr  input  32  byte address.
REQ-009 SHALL have port i_data  input  32  write data.
REQ-010 SHALL have port o_accept  output  1  request completes this cycle.
REQ-011 SHALL have port o_data  output  32  read data, valid when o_accept=1.
REQ-012 SHALL have port i_ld_en  input  1  preload write strobe.
REQ-013 SHALL have port i_ld_addr  input  $clog2(DEPTH)  preload word index.
REQ-014 SHALL have port i_ld_data  input  32  preload data.
REQ-015 SHALL have port o_err  output  1  sticky out-of-range flag.

Function
REQ-016 SHALL treat a request as a hit when BASE <= i_addr < BASE+4*DEPTH; word index = (i_addr-BASE)[log2(DEPTH)+1:2]; i_addr[1:0] ignored.
REQ-017 SHALL implement a wait counter cnt_q (4 bits) with states IDLE (cnt_q=0) and WAIT (cnt_q>0).
REQ-018 SHALL drive o_accept = i_valid & ~i_ld_en & (cnt_q == WAIT), combinationally.
REQ-019 SHALL update cnt_q: 0 on accept, 0 if i_valid=0, hold when i_ld_en=1, else cnt_q+1.
REQ-020 SHALL give latency: accept in the (WAIT+1)th consecutive cycle of i_valid; WAIT=0 accepts in the first cycle.
REQ-021 SHALL, if i_valid drops before accept, abandon the request with no memory side effect and return to IDLE.
REQ-022 SHALL support back-to-back requests: i_valid held high after an accept is a new request starting from cnt_q=0.
REQ-023 SHALL present o_data = mem[index] combinationally in the accept cycle for hit reads; o_data=0 otherwise.
REQ-024 SHALL write i_data to mem[index] at the clock edge ending an accepted hit write.
REQ-025 SHALL accept out-of-range requests after the normal wait: reads return 0, writes are dropped, o_err set on the next edge.
REQ-026 SHALL hold o_err at 1 until reset.
REQ-027 SHALL write i_ld_data to mem[i_ld_addr] on each edge with i_ld_en=1; the loader has priority and stalls the bus (no accept).
REQ-028 SHALL make a read accepted the cycle after a write to the same word return the new data.

Reset
REQ-029 SHALL, while i_nrst=0 at an edge, clear cnt_q to 0 and o_err to 0.
REQ-030 SHALL force o_accept=0 while i_nrst=0; o_data then reads 0.
REQ-031 SHALL leave memory contents unchanged by reset; a request in flight is abandoned with no write.

Configuration
REQ-032 SHALL honour macro X_MEM_RESP_WAIT_EN: defined -> counter per REQ-017..022 using WAIT.
REQ-033 SHALL, without X_MEM_RESP_WAIT_EN, omit cnt_q, ignore WAIT, and drive o_accept = i_valid & ~i_ld_en (zero wait).

Verification
REQ-034 SHALL verify preload: i_ld_en writes 32'h0000_0013 to word 0; read of addr 0 with WAIT=2 -> o_accept in 3rd cycle, o_data=32'h0000_0013.
REQ-035 SHALL verify write-then-read: write 32'hCAFE_F00D to addr 0x10, then back-to-back read of 0x10 -> o_data=32'hCAFE_F00D, two accepts 3 cycles apart.
REQ-036 SHALL verify out-of-range: read addr BASE+4*DEPTH -> accepted after WAIT, o_data=0, o_err=1 next cycle and stays 1.
REQ-037 SHALL verify abandonment: i_valid write high 2 cycles then low (WAIT=2) -> no accept, memory unchanged, next request starts from count 0.
REQ-038 SHALL verify loader stall: i_ld_en high during a pending read -> o_accept stays 0, accept 1 cycle after i_ld_en falls.
REQ-039 SHALL verify reset mid-wait: i_nrst low with cnt_q=1 -> o_accept=0, o_err=0, memory unchanged.

Source files
------------

// File: rtl/x_mem_resp.sv
// ============================================================================
// Module   : x_mem_resp
// Brief    : Word-addressed memory responder with a valid/accept handshake, an
//            optional wait counter (macro X_MEM_RESP_WAIT_EN), a preload port
//            with priority over the bus, and a sticky out-of-range flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module x_mem_resp #(
    parameter int unsigned DEPTH = 256,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int unsigned WAIT  = 2
) (
    input  logic                     i_clk,
    input  logic                     i_nrst,
    input  logic                     i_valid,
    input  logic                     i_rnw,
    input  logic [31:0]              i_addr,
    input  logic [31:0]              i_data,
    output logic                     o_accept,
    output logic [31:0]              o_data,
    input  logic                     i_ld_en,
    input  logic [$clog2(DEPTH)-1:0] i_ld_addr,
    input  logic [31:0]              i_ld_data,
    output logic                     o_err
);

    localparam int unsigned AW     = $clog2(DEPTH);
    localparam logic [32:0] c_span = 33'(4 * DEPTH);

    // Elaboration-time guard on the configuration range.
    generate
        if ((DEPTH < 4) || (DEPTH > 4096) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
            $error("x_mem_resp: DEPTH must be a power of two in 4..4096");
        end
        if (WAIT > 15) begin : g_bad_wait
            $error("x_mem_resp: WAIT must be in 0..15");
        end
    endgenerate

    logic [32:0]   w_off;
    logic          w_hit;
    logic [AW-1:0] w_idx;
    logic          w_cnt_done;
    logic          r_err;
    logic [31:0]   r_mem [DEPTH];

    // A 33-bit offset makes addresses below BASE wrap huge, so one compare covers both ends.
    assign w_off = {1'b0, i_addr} - {1'b0, BASE};
    assign w_hit = (w_off < c_span);
    assign w_idx = w_off[AW+1:2];

`ifdef X_MEM_RESP_WAIT_EN
    localparam logic [3:0] c_wait = 4'(WAIT);

    logic [3:0] r_cnt_q;

    assign w_cnt_done = (r_cnt_q == c_wait);

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_cnt_q <= 4'd0;
        end else if (!i_valid) begin
            r_cnt_q <= 4'd0;
        end else if (i_ld_en) begin
            r_cnt_q <= r_cnt_q;
        end else if (w_cnt_done) begin
            r_cnt_q <= 4'd0;
        end else begin
            r_cnt_q <= r_cnt_q + 4'd1;
        end
    end
`else
    assign w_cnt_done = 1'b1;
`endif

    assign o_accept = i_nrst & i_valid & ~i_ld_en & w_cnt_done;
    assign o_data   = (o_accept & i_rnw & w_hit) ? r_mem[w_idx] : 32'd0;
    assign o_err    = r_err;

    // Loader and bus write never coincide because the loader suppresses accept.
    always_ff @(posedge i_clk) begin
        if (i_ld_en) begin
            r_mem[i_ld_addr] <= i_ld_data;
        end else if (o_accept && !i_rnw && w_hit) begin
            r_mem[w_idx] <= i_data;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_nrst) begin
            r_err <= 1'b0;
        end else if (o_accept && !w_hit) begin
            r_err <= 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_x_mem_resp.sv
// ============================================================================
// Module   : tb_x_mem_resp
// Brief    : Scoreboard bench for x_mem_resp; expected latency follows the
//            X_MEM_RESP_WAIT_EN build (WAIT cycles when defined, else zero).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_x_mem_resp;

    localparam int unsigned DEPTH = 256;
    localparam int unsigned WAIT  = 2;
`ifdef X_MEM_RESP_WAIT_EN
    localparam int EW = WAIT;
`else
    localparam int EW = 0;
`endif

    logic        i_clk;
    logic        i_nrst;
    logic        i_valid;
    logic        i_rnw;
    logic [31:0] i_addr;
    logic [31:0] i_data;
    logic        o_accept;
    logic [31:0] o_data;
    logic        i_ld_en;
    logic [7:0]  i_ld_addr;
    logic [31:0] i_ld_data;
    logic        o_err;

    x_mem_resp #(.DEPTH(DEPTH), .BASE(32'h0000_0000), .WAIT(WAIT)) dut (
        .i_clk    (i_clk),
        .i_nrst   (i_nrst),
        .i_valid  (i_valid),
        .i_rnw    (i_rnw),
        .i_addr   (i_addr),
        .i_data   (i_data),
        .o_accept (o_accept),
        .o_data   (o_data),
        .i_ld_en  (i_ld_en),
        .i_ld_addr(i_ld_addr),
        .i_ld_data(i_ld_data),
        .o_err    (o_err)
    );

    typedef struct {
        logic [31:0] data;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_mem [DEPTH];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc_cnt = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc_cnt <= cyc_cnt + 1;

    // Holds a request until accepted (bounded); returns at 1 time unit past the edge.
    task automatic drive_req(input logic rnw, input logic [31:0] addr, input logic [31:0] wdata,
                             input bit keep, output int lat, output logic [31:0] rdata,
                             output int acc_cyc, output bit got);
        i_valid = 1'b1;
        i_rnw   = rnw;
        i_addr  = addr;
        i_data  = wdata;
        got     = 1'b0;
        lat     = 0;
        rdata   = 32'd0;
        acc_cyc = -1;
        for (int k = 0; k < 32 && !got; k++) begin
            @(negedge i_clk);
            lat = lat + 1;
            if (o_accept === 1'b1) begin
                got     = 1'b1;
                rdata   = o_data;
                acc_cyc = cyc_cnt;
            end
            @(posedge i_clk);
            #1;
        end
        if (!keep) i_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_nrst  = 1'b0;
        i_valid = 1'b1;
        i_rnw   = 1'b1;
        i_addr  = 32'd0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        n_cmp++;
        if (o_accept !== 1'b0) begin
            n_err++;
            $display("FAIL reset_accept: got %b want 0", o_accept);
        end
        n_cmp++;
        if (o_err !== 1'b0 || o_data !== 32'd0) begin
            n_err++;
            $display("FAIL reset_err_data: got err=%b data=%h want err=0 data=0", o_err, o_data);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_nrst  = 1'b1;
    endtask

    task automatic test_preload();
        int          lat;
        int          acy;
        bit          got;
        logic [31:0] rd;
        logic [31:0] addrs[4];
        exp_t        e;
        i_ld_en = 1'b1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            i_ld_addr = 8'(i);
            i_ld_data = 32'hA5A5_0000 ^ (32'(i) * 32'h0101_0101);
            m_mem[i]  = i_ld_data;
            @(posedge i_clk);
            #1;
        end
        i_ld_addr = 8'd0;
        i_ld_data = 32'h0000_0013;
        m_mem[0]  = 32'h0000_0013;
        @(posedge i_clk);
        #1;
        i_ld_en = 1'b0;
        addrs[0] = 32'h0000_0000;
        addrs[1] = 32'h0000_0003;
        addrs[2] = 32'h0000_0016;
        addrs[3] = 32'(4 * (DEPTH - 1));
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{data: m_mem[addrs[i][9:2]], lat: EW + 1});
            drive_req(1'b1, addrs[i], 32'd0, 1'b0, lat, rd, acy, got);
            e = sb.pop_front();
            n_cmp++;
            if (!got || lat !== e.lat) begin
                n_err++;
                $display("FAIL preload_lat[%0d]: got accepted=%0b in cycle %0d want cycle %0d", i, got, lat, e.lat);
            end
            n_cmp++;
            if (rd !== e.data) begin
                n_err++;
                $display("FAIL preload_data[%0d]: got %h want %h", i, rd, e.data);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          lat_w, lat_r, acy_w, acy_r;
        bit          got_w, got_r;
        logic [31:0] rd_w, rd_r;
        exp_t        e;
        sb.push_back('{data: 32'd0, lat: EW + 1});
        sb.push_back('{data: 32'hCAFE_F00D, lat: EW + 1});
        drive_req(1'b0, 32'h0000_0010, 32'hCAFE_F00D, 1'b1, lat_w, rd_w, acy_w, got_w);
        drive_req(1'b1, 32'h0000_0010, 32'd0, 1'b0, lat_r, rd_r, acy_r, got_r);
        m_mem[4] = 32'hCAFE_F00D;
        e = sb.pop_front();
        n_cmp++;
        if (!got_w || lat_w !== e.lat || rd_w !== e.data) begin
            n_err++;
            $display("FAIL b2b_write: got acc=%0b cycle=%0d data=%h want cycle %0d data %h", got_w, lat_w, rd_w, e.lat, e.data);
        end
        e = sb.pop_front();
        n_cmp++;
        if (!got_r || rd_r !== e.data) begin
            n_err++;
            $display("FAIL b2b_read_data: got acc=%0b data=%h want %h", got_r, rd_r, e.data);
        end
        n_cmp++;
        if (acy_r - acy_w !== EW + 1) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d cycles want %0d", acy_r - acy_w, EW + 1);
        end
    endtask

    task automatic test_out_of_range();
        int          lat;
        int          acy;
        bit          got;
        logic [31:0] rd;
        exp_t        e;
        sb.push_back('{data: 32'd0, lat: EW + 1});
        drive_req(1'b1, 32'(4 * DEPTH), 32'd0, 1'b0, lat, rd, acy, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || lat !== e.lat || rd !== e.data) begin
            n_err++;
            $display("FAIL oor_read: got acc=%0b cycle=%0d data=%h want cycle %0d data %h", got, lat, rd, e.lat, e.data);
        end
        n_cmp++;
        if (o_err !== 1'b1) begin
            n_err++;
            $display("FAIL oor_err_set: got %b want 1", o_err);
        end
        // The aliased write must be dropped: its low bits select word 4.
        drive_req(1'b0, 32'(4 * DEPTH + 16), 32'hDEAD_BEEF, 1'b0, lat, rd, acy, got);
        sb.push_back('{data: 32'd0, lat: EW + 1});
        drive_req(1'b1, 32'hFFFF_FFFC, 32'd0, 1'b0, lat, rd, acy, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || rd !== e.data) begin
            n_err++;
            $display("FAIL oor_top_read: got acc=%0b data=%h want %h", got, rd, e.data);
        end
        sb.push_back('{data: m_mem[4], lat: EW + 1});
        drive_req(1'b1, 32'h0000_0010, 32'd0, 1'b0, lat, rd, acy, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || rd !== e.data) begin
            n_err++;
            $display("FAIL oor_write_dropped: got acc=%0b data=%h want %h", got, rd, e.data);
        end
        repeat (4) @(posedge i_clk);
        #1;
        n_cmp++;
        if (o_err !== 1'b1) begin
            n_err++;
            $display("FAIL oor_err_sticky: got %b want 1", o_err);
        end
    endtask

    task automatic test_abandon();
        int          lat;
        int          acy;
        int          stray;
        bit          got;
        logic [31:0] rd;
        exp_t        e;
        stray   = 0;
        i_valid = 1'b1;
        i_rnw   = 1'b0;
        i_addr  = 32'h0000_0030;
        i_data  = 32'h0BAD_0BAD;
        for (int k = 0; k < EW; k++) begin
            @(negedge i_clk);
            if (o_accept !== 1'b0) stray++;
            @(posedge i_clk);
            #1;
        end
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        n_cmp++;
        if (stray !== 0) begin
            n_err++;
            $display("FAIL abandon_no_accept: got %0d accepts want 0", stray);
        end
        sb.push_back('{data: m_mem[12], lat: EW + 1});
        drive_req(1'b1, 32'h0000_0030, 32'd0, 1'b0, lat, rd, acy, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || lat !== e.lat) begin
            n_err++;
            $display("FAIL abandon_restart_lat: got acc=%0b cycle=%0d want cycle %0d", got, lat, e.lat);
        end
        n_cmp++;
        if (rd !== e.data) begin
            n_err++;
            $display("FAIL abandon_mem: got %h want %h", rd, e.data);
        end
    endtask

    task automatic test_loader_stall();
        int   stray;
        exp_t e;
        stray   = 0;
        i_valid = 1'b1;
        i_rnw   = 1'b1;
        i_addr  = 32'h0000_001C;
        for (int k = 0; k < EW; k++) begin
            @(negedge i_clk);
            if (o_accept !== 1'b0) stray++;
            @(posedge i_clk);
            #1;
        end
        i_ld_en   = 1'b1;
        i_ld_addr = 8'd7;
        i_ld_data = 32'h7777_1234;
        m_mem[7]  = 32'h7777_1234;
        sb.push_back('{data: 32'h7777_1234, lat: 1});
        repeat (3) begin
            @(negedge i_clk);
            if (o_accept !== 1'b0) stray++;
            @(posedge i_clk);
            #1;
        end
        i_ld_en = 1'b0;
        n_cmp++;
        if (stray !== 0) begin
            n_err++;
            $display("FAIL stall_no_accept: got %0d accepts want 0", stray);
        end
        @(negedge i_clk);
        e = sb.pop_front();
        n_cmp++;
        if (o_accept !== 1'b1 || o_data !== e.data) begin
            n_err++;
            $display("FAIL stall_release: got acc=%b data=%h want acc=1 data=%h", o_accept, o_data, e.data);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic test_reset_midwait();
        int          lat;
        int          acy;
        int          stray;
        bit          got;
        logic [31:0] rd;
        exp_t        e;
        stray   = 0;
        i_valid = 1'b1;
        i_rnw   = 1'b0;
        i_addr  = 32'h0000_0024;
        i_data  = 32'h1234_5678;
        for (int k = 0; k < ((EW > 0) ? 1 : 0); k++) begin
            @(negedge i_clk);
            if (o_accept !== 1'b0) stray++;
            @(posedge i_clk);
            #1;
        end
        i_nrst = 1'b0;
        @(negedge i_clk);
        if (o_accept !== 1'b0 || o_data !== 32'd0) stray++;
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        if (o_accept !== 1'b0) stray++;
        n_cmp++;
        if (stray !== 0) begin
            n_err++;
            $display("FAIL rst_mid_accept: got %0d accepts want 0", stray);
        end
        n_cmp++;
        if (o_err !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_err: got %b want 0", o_err);
        end
        @(posedge i_clk);
        #1;
        i_nrst  = 1'b1;
        i_valid = 1'b0;
        @(posedge i_clk);
        #1;
        sb.push_back('{data: m_mem[9], lat: EW + 1});
        drive_req(1'b1, 32'h0000_0024, 32'd0, 1'b0, lat, rd, acy, got);
        e = sb.pop_front();
        n_cmp++;
        if (!got || lat !== e.lat || rd !== e.data) begin
            n_err++;
            $display("FAIL rst_mid_mem: got acc=%0b cycle=%0d data=%h want cycle %0d data %h", got, lat, rd, e.lat, e.data);
        end
    endtask

    initial begin
        i_nrst    = 1'b0;
        i_valid   = 1'b0;
        i_rnw     = 1'b1;
        i_addr    = 32'd0;
        i_data    = 32'd0;
        i_ld_en   = 1'b0;
        i_ld_addr = 8'd0;
        i_ld_data = 32'd0;
        @(posedge i_clk);
        #1;
        test_reset();
        test_preload();
        test_back_to_back();
        test_out_of_range();
        test_abandon();
        test_loader_stall();
        test_reset_midwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
